// File: rtl/serial_tx_ctrl_pkg.sv
// serial_tx_ctrl_pkg: shared FSM encoding and line levels for the serial transmitter
package serial_tx_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam logic LINE_IDLE = 1'b1;
endpackage

// File: rtl/serial_tx_ctrl_shift_reg.sv
// shift_reg: loadable bidirectional shift register exposing its two lowest bits
module shift_reg #(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_ce,
    input  logic         i_we,
    input  logic         i_shift_right,
    input  logic         i_shift_left,
    input  logic [N-1:0] i_data,
    output logic         o_bit0,
    output logic         o_bit1
);
    logic [N-1:0] q;

    always_ff @(posedge i_clk)
        if (i_reset) q <= '0;
        else if (i_ce) q <= i_we ? i_data : i_shift_right ? q >> 1 : i_shift_left ? q << 1 : q;

    assign o_bit0 = q[0];
    // o_bit1 is the value bit 0 takes after a right shift
    generate
        if (N > 1) begin : g_wide
            assign o_bit1 = q[1];
        end else begin : g_narrow
            assign o_bit1 = 1'b0;
        end
    endgenerate
endmodule

// File: rtl/serial_tx_ctrl.sv
// serial_tx_ctrl: start/data/stop framing serializer with per-bit clock-enable timing
module serial_tx_ctrl
    import serial_tx_ctrl_pkg::*;
#(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_ce,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_data,
    output logic         o_serial,
    output logic         o_busy,
    output logic         o_done
);
    localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_MAX = CW'(N - 1);

    state_t state, state_d;
    logic [BW-1:0] baud_cnt;
    logic [CW-1:0] bit_cnt;
    logic accept, bit_end, shift_right, sr_bit0, sr_bit1;
    logic serial_d, ready_d, busy_d, done_d;

    assign accept      = i_ce && i_valid && state == IDLE;
    assign bit_end     = i_ce && state != IDLE && baud_cnt == BAUD_MAX;
    assign shift_right = bit_end && state == DATA;

    shift_reg #(.N(N)) u_shift_reg (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_ce         (1'b1),
        .i_we         (accept),
        .i_shift_right(shift_right),
        .i_shift_left (1'b0),
        .i_data       (i_data),
        .o_bit0       (sr_bit0),
        .o_bit1       (sr_bit1)
    );

    always_ff @(posedge i_clk)
        if (i_reset) state <= IDLE;
        else if (i_ce) state <= state_d;

    always_comb begin
        state_d = state == IDLE ? (i_valid ? START : IDLE)
                : !bit_end      ? state
                : state == START ? DATA
                : state == DATA  ? (bit_cnt == BIT_MAX ? STOP : DATA)
                : IDLE;
    end

    always_ff @(posedge i_clk)
        if (i_reset) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (i_ce) begin
            baud_cnt <= (state == IDLE || baud_cnt == BAUD_MAX) ? '0 : baud_cnt + 1'b1;
            bit_cnt  <= state != DATA ? '0 : (bit_end && bit_cnt != BIT_MAX) ? bit_cnt + 1'b1 : bit_cnt;
        end

    // Outputs are computed for the upcoming state so they can be registered without lag
    always_comb begin
        serial_d = state_d == START ? 1'b0
                 : state_d == DATA  ? (shift_right ? sr_bit1 : sr_bit0)
                 : LINE_IDLE;
        ready_d  = state_d == IDLE;
        busy_d   = state_d != IDLE;
        done_d   = state == STOP && state_d == IDLE;
    end

    always_ff @(posedge i_clk)
        if (i_reset) begin
            o_serial <= LINE_IDLE;
            o_ready  <= 1'b1;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else if (i_ce) begin
            o_serial <= serial_d;
            o_ready  <= ready_d;
            o_busy   <= busy_d;
            o_done   <= done_d;
        end else begin
            o_done   <= 1'b0;
        end
endmodule

// File: tb/tb_serial_tx_ctrl.sv
// tb_serial_tx_ctrl: directed and random frames checked against a queue-based line model
module tb_serial_tx_ctrl;
    localparam int N = 8;
    localparam int C = 4;

    logic         i_clk = 1'b0;
    logic         i_reset, i_ce, i_valid;
    logic [N-1:0] i_data;
    logic         o_ready, o_serial, o_busy, o_done;

    int checks = 0;
    int failures = 0;
    logic exp_serial = 1'b1, exp_ready = 1'b1, exp_busy = 1'b0, exp_done = 1'b0;
    bit line_q[$];

    always #5 i_clk = ~i_clk;

    serial_tx_ctrl #(.N(N), .CLKS_PER_BIT(C)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_ce    (i_ce),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_serial(o_serial),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // The model holds the line level for every remaining enabled clock of the frame
    task automatic step;
        bit was_empty;
        bit v;
        @(posedge i_clk);
        if (i_reset) begin
            line_q.delete();
            exp_done = 1'b0;
        end else if (i_ce) begin
            was_empty = line_q.size() == 0;
            if (!was_empty) begin
                void'(line_q.pop_front());
                exp_done = line_q.size() == 0;
            end else exp_done = 1'b0;
            if (was_empty && i_valid)
                for (int b = 0; b < N + 2; b++) begin
                    v = b == 0 ? 1'b0 : b == N + 1 ? 1'b1 : i_data[b-1];
                    repeat (C) line_q.push_back(v);
                end
        end else exp_done = 1'b0;
        if (i_reset || i_ce) begin
            exp_busy   = line_q.size() != 0;
            exp_ready  = !exp_busy;
            exp_serial = exp_busy ? line_q[0] : 1'b1;
        end
        #1;
        check("serial", o_serial, exp_serial);
        check("ready", o_ready, exp_ready);
        check("busy", o_busy, exp_busy);
        check("done", o_done, exp_done);
    endtask

    task automatic drive(input logic r, input logic ce, input logic v, input logic [N-1:0] d);
        i_reset = r;
        i_ce    = ce;
        i_valid = v;
        i_data  = d;
        step();
    endtask

    initial begin
        int lat, dones;
        i_reset = 1'b1;
        i_ce    = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        repeat (2) drive(1'b1, 1'b1, 1'b0, '0);
        check("rst_serial", o_serial, 1);
        check("rst_ready", o_ready, 1);

        drive(1'b0, 1'b1, 1'b1, 8'hA5);
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            drive(1'b0, 1'b1, 1'b0, N'($urandom));
            if (o_done && lat < 0) lat = i;
        end
        check("a5_done_latency", lat, 40);

        drive(1'b0, 1'b1, 1'b1, 8'h00);
        dones = 0;
        for (int i = 1; i <= 85; i++) begin
            drive(1'b0, 1'b1, 1'b1, 8'hFF);
            dones += int'(o_done);
        end
        check("b2b_dones", dones, 2);
        repeat (45) drive(1'b0, 1'b1, 1'b0, N'($urandom));

        drive(1'b0, 1'b1, 1'b1, 8'h81);
        dones = 0;
        for (int i = 1; i <= 90; i++) begin
            drive(1'b0, i % 2 == 0, i == 20, i == 20 ? 8'h3C : N'($urandom));
            if (i == 20) check("ignored_ready", o_ready, 0);
            dones += int'(o_done);
        end
        check("ce_dones", dones, 1);

        drive(1'b0, 1'b1, 1'b1, 8'h33);
        repeat (17) drive(1'b0, 1'b1, 1'b0, N'($urandom));
        drive(1'b1, 1'b1, 1'b1, 8'hC3);
        check("rst_mid_serial", o_serial, 1);
        check("rst_mid_done", o_done, 0);
        drive(1'b0, 1'b1, 1'b1, 8'h55);
        dones = 0;
        for (int i = 1; i <= 45; i++) begin
            drive(1'b0, 1'b1, 1'b0, N'($urandom));
            dones += int'(o_done);
        end
        check("post_rst_dones", dones, 1);

        for (int i = 0; i < 3000; i++)
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 4) != 0,
                  $urandom_range(0, 2) == 0, N'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
